// File: rtl/tri_proj_asm_if.sv
// rtl/tri_proj_asm_if.sv - vertex-in / triangle-out handshake bundle for tri_proj_asm
interface tri_proj_asm_if #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 9
);
   logic [3:0][IN_W-1:0]       coor_in;
   logic                       valid_in;
   logic                       obj_done_in;
   logic                       ready_out;
   logic [2:0][2:0][OUT_W-1:0] coor_out;
   logic                       valid_out;
   logic                       ready_in;
   logic                       obj_done_out;
   logic                       tri_drop_out;

   modport slave (
      input  coor_in, valid_in, obj_done_in, ready_in,
      output ready_out, coor_out, valid_out, obj_done_out, tri_drop_out
   );

   modport master (
      output coor_in, valid_in, obj_done_in, ready_in,
      input  ready_out, coor_out, valid_out, obj_done_out, tri_drop_out
   );
endinterface

// File: rtl/tri_proj_asm.sv
// rtl/tri_proj_asm.sv - perspective projection and triangle assembly
// Define TRI_PROJ_CULL_EN to add a back-face culling cycle before emit.
module tri_proj_asm #(
   parameter int IN_W     = 32,
   parameter int FRAC     = 16,
   parameter int OUT_W    = 9,
   parameter int FOCAL    = 160,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter logic signed [IN_W-1:0] NEAR_Z = 32'h0001_0000
) (
   input  logic          clk_in,
   input  logic          rst_in,
   tri_proj_asm_if.slave bus
);
   localparam int FW = $clog2(FOCAL + 1);
   localparam int W  = IN_W + OUT_W + FW + 1;
   localparam int QW = OUT_W + 1;
   localparam int SW = OUT_W + 4;
   localparam int CW = $clog2(OUT_W + 3);
   localparam logic [CW-1:0]        LAST  = CW'(OUT_W + 2);
   localparam logic signed [SW-1:0] X_MID = SW'(SCREEN_W / 2);
   localparam logic signed [SW-1:0] Y_MID = SW'(SCREEN_H / 2);
   localparam logic signed [SW-1:0] X_MAX = SW'(SCREEN_W - 1);
   localparam logic signed [SW-1:0] Y_MAX = SW'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      S_ACCEPT, S_DIV, S_EMIT
`ifdef TRI_PROJ_CULL_EN
      , S_CULL
`endif
   } state_t;

   state_t                     state, state_n;
   logic [CW-1:0]              cnt;
   logic [1:0]                 vcnt;
   logic [IN_W-1:0]            x_r, y_r, z_r;
   logic [W-1:0]               rem_x, rem_y, dsh;
   logic [QW-1:0]              q_x, q_y;
   logic                       sat_x, sat_y, neg_x, neg_y;
   logic [2:0]                 bad_r;
   logic                       od_acc, od_q, drop_q;
   logic [2:0][2:0][OUT_W-1:0] coor_q;

   logic [IN_W-1:0]        ax, ay, az;
   logic [W-1:0]           nx, ny, dz;
   logic signed [SW-1:0]   sx, sy, xs, ys;
   logic signed [IN_W-1:0] zi;
   logic [OUT_W-1:0]       xs_c, ys_c, zs_c;
   logic                   cur_bad, any_bad, accept, drop_ev, retire_ev;

   // w is carried on the bus for the fetch stage but not used here
   wire unused_w = &{1'b0, bus.coor_in[0]};

   always_comb begin
      ax = x_r[IN_W-1] ? ~x_r + 1'b1 : x_r;
      ay = y_r[IN_W-1] ? ~y_r + 1'b1 : y_r;
      az = z_r[IN_W-1] ? ~z_r + 1'b1 : z_r;
      nx = W'(ax) * W'(FOCAL);
      ny = W'(ay) * W'(FOCAL);
      dz = W'(az);
      sx = SW'(sat_x ? {QW{1'b1}} : q_x);
      sy = SW'(sat_y ? {QW{1'b1}} : q_y);
      if (neg_x) sx = -sx;
      if (neg_y) sy = -sy;
      xs = X_MID + sx;
      ys = Y_MID - sy;
      xs_c = (xs < 0) ? '0 : (xs > X_MAX) ? OUT_W'(SCREEN_W - 1) : xs[OUT_W-1:0];
      ys_c = (ys < 0) ? '0 : (ys > Y_MAX) ? OUT_W'(SCREEN_H - 1) : ys[OUT_W-1:0];
      zi = $signed(z_r) >>> FRAC;
      if (z_r[IN_W-1])                                zs_c = '0;
      else if (zi > $signed(IN_W'(2**OUT_W - 1)))      zs_c = '1;
      else                                            zs_c = zi[OUT_W-1:0];
      cur_bad = $signed(z_r) < NEAR_Z;
      any_bad = bad_r[0] | bad_r[1] | cur_bad;
   end

`ifdef TRI_PROJ_CULL_EN
   localparam int AW = 2 * OUT_W + 3;
   logic signed [AW-1:0] area;
   always_comb begin
      area = (AW'(coor_q[1][2]) - AW'(coor_q[0][2])) * (AW'(coor_q[2][1]) - AW'(coor_q[0][1]))
           - (AW'(coor_q[2][2]) - AW'(coor_q[0][2])) * (AW'(coor_q[1][1]) - AW'(coor_q[0][1]));
   end
`endif

   always_comb begin
      accept  = (state == S_ACCEPT) && bus.valid_in;
      drop_ev = 1'b0;
`ifdef TRI_PROJ_CULL_EN
      if (state == S_CULL) drop_ev = (|bad_r) || (area <= 0);
`else
      if (state == S_DIV && cnt == LAST && vcnt == 2'd2) drop_ev = any_bad;
`endif
      retire_ev = drop_ev || (state == S_EMIT && bus.ready_in);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= S_ACCEPT;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_ACCEPT: if (bus.valid_in) state_n = S_DIV;
         S_DIV: begin
            if (cnt == LAST) begin
               if (vcnt != 2'd2)  state_n = S_ACCEPT;
`ifdef TRI_PROJ_CULL_EN
               else               state_n = S_CULL;
`else
               else               state_n = any_bad ? S_ACCEPT : S_EMIT;
`endif
            end
         end
`ifdef TRI_PROJ_CULL_EN
         S_CULL:   state_n = drop_ev ? S_ACCEPT : S_EMIT;
`endif
         S_EMIT:   if (bus.ready_in) state_n = S_ACCEPT;
         default:  state_n = S_ACCEPT;
      endcase
   end

   always_comb begin
      bus.ready_out    = (state == S_ACCEPT) && !rst_in;
      bus.valid_out    = (state == S_EMIT);
      bus.coor_out     = coor_q;
      bus.tri_drop_out = drop_q;
      bus.obj_done_out = od_q;
   end

   // cnt 0 loads the dividers, 1..OUT_W+1 iterate, LAST maps and stores the vertex
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt <= '0;  vcnt <= '0;
         x_r <= '0;  y_r <= '0;  z_r <= '0;
         rem_x <= '0; rem_y <= '0; dsh <= '0;
         q_x <= '0;  q_y <= '0;
         sat_x <= 1'b0; sat_y <= 1'b0; neg_x <= 1'b0; neg_y <= 1'b0;
         bad_r <= '0; od_acc <= 1'b0; od_q <= 1'b0; drop_q <= 1'b0;
         coor_q <= '0;
      end else begin
         drop_q <= drop_ev;
         od_q   <= retire_ev & od_acc;
         if (retire_ev) od_acc <= 1'b0;
         if (accept) begin
            x_r    <= bus.coor_in[3];
            y_r    <= bus.coor_in[2];
            z_r    <= bus.coor_in[1];
            od_acc <= od_acc | bus.obj_done_in;
            cnt    <= '0;
         end
         if (state == S_DIV) begin
            cnt <= cnt + 1'b1;
            if (cnt == '0) begin
               rem_x <= nx;
               rem_y <= ny;
               dsh   <= dz << OUT_W;
               sat_x <= nx >= (dz << QW);
               sat_y <= ny >= (dz << QW);
               neg_x <= x_r[IN_W-1] ^ z_r[IN_W-1];
               neg_y <= y_r[IN_W-1] ^ z_r[IN_W-1];
               q_x   <= '0;
               q_y   <= '0;
            end else if (cnt != LAST) begin
               if (rem_x >= dsh) rem_x <= rem_x - dsh;
               if (rem_y >= dsh) rem_y <= rem_y - dsh;
               q_x <= {q_x[QW-2:0], rem_x >= dsh};
               q_y <= {q_y[QW-2:0], rem_y >= dsh};
               dsh <= dsh >> 1;
            end else begin
               coor_q[vcnt] <= {xs_c, ys_c, zs_c};
               bad_r[vcnt]  <= cur_bad;
               vcnt         <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_tri_proj_asm.sv
// tb/tb_tri_proj_asm.sv - randomized self-checking bench for tri_proj_asm against a projection model
module tb_tri_proj_asm;
   localparam longint ONE = 65536;
`ifdef TRI_PROJ_CULL_EN
   localparam int  LAT     = 13;
   localparam bit  CULL_ON = 1'b1;
`else
   localparam int  LAT     = 12;
   localparam bit  CULL_ON = 1'b0;
`endif
   localparam int  V_LAT = 12;

   logic clk_in, rst_in;
   int   n_tests, n_fail;

   longint tv_x[3], tv_y[3], tv_z[3];
   bit     tv_od[3];

   tri_proj_asm_if #(.IN_W(32), .OUT_W(9)) bus ();

   tri_proj_asm dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", tag, got, exp);
      end
   endtask

   // Screen-space vertex derived directly from the projection rules
   function automatic void proj(input longint x, input longint y, input longint z,
                                output longint xs, output longint ys, output longint zs,
                                output bit bad);
      longint ax, ay, az, qx, qy;
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      az = (z < 0) ? -z : z;
      qx = (az == 0) ? 1023 : (ax * 160) / az;
      qy = (az == 0) ? 1023 : (ay * 160) / az;
      if (qx > 1023) qx = 1023;
      if (qy > 1023) qy = 1023;
      if ((x < 0) != (z < 0)) qx = -qx;
      if ((y < 0) != (z < 0)) qy = -qy;
      xs = 160 + qx;
      ys = 120 - qy;
      if (xs < 0) xs = 0;
      if (xs > 319) xs = 319;
      if (ys < 0) ys = 0;
      if (ys > 239) ys = 239;
      zs = (z < 0) ? 0 : (((z >>> 16) > 511) ? 511 : (z >>> 16));
      bad = (z < ONE);
   endfunction

   task automatic set_v(input int i, input longint x, input longint y, input longint z, input bit od);
      tv_x[i] = x; tv_y[i] = y; tv_z[i] = z; tv_od[i] = od;
   endtask

   task automatic send_vertex(input int i);
      int n;
      bus.coor_in[3] = tv_x[i][31:0];
      bus.coor_in[2] = tv_y[i][31:0];
      bus.coor_in[1] = tv_z[i][31:0];
      bus.coor_in[0] = 32'h0001_0000;
      bus.obj_done_in = tv_od[i];
      bus.valid_in = 1'b1;
      n = 0;
      while (!bus.ready_out && n < 60) begin
         @(posedge clk_in); #1; n++;
      end
      if (n >= 60) check("accept_timeout", 0, 1);
      @(posedge clk_in); #1;
      bus.valid_in = 1'b0;
      bus.obj_done_in = 1'b0;
   endtask

   // Offer junk while busy: it must be ignored
   task automatic wait_ready(input string tag);
      int k;
      bit junk;
      k = 0;
      junk = 1'($urandom_range(0, 1));
      do begin
         @(posedge clk_in); #1; k++;
         if (junk && k < 8) begin
            bus.coor_in[3] = $urandom;
            bus.coor_in[2] = $urandom;
            bus.coor_in[1] = $urandom;
            bus.obj_done_in = 1'b1;
            bus.valid_in = 1'b1;
         end else begin
            bus.valid_in = 1'b0;
            bus.obj_done_in = 1'b0;
         end
      end while (!bus.ready_out && k < 40);
      bus.valid_in = 1'b0;
      check(tag, k, V_LAT);
   endtask

   task automatic run_tri(input int hold);
      longint ex[3], ey[3], ez[3], area;
      bit b, any_bad, od, drop, stable;
      int k;
      logic [2:0][2:0][8:0] snap;
      any_bad = 1'b0;
      od = 1'b0;
      for (int i = 0; i < 3; i++) begin
         proj(tv_x[i], tv_y[i], tv_z[i], ex[i], ey[i], ez[i], b);
         any_bad |= b;
         od |= tv_od[i];
      end
      area = (ex[1] - ex[0]) * (ey[2] - ey[0]) - (ex[2] - ex[0]) * (ey[1] - ey[0]);
      drop = any_bad || (CULL_ON && area <= 0);

      send_vertex(0);
      wait_ready("v0_ready_lat");
      send_vertex(1);
      wait_ready("v1_ready_lat");
      send_vertex(2);
      k = 0;
      while (!bus.valid_out && !bus.tri_drop_out && k < 40) begin
         @(posedge clk_in); #1; k++;
      end
      check("tri_lat", k, LAT);
      if (drop) begin
         check("drop_pulse", bus.tri_drop_out, 1);
         check("drop_no_valid", bus.valid_out, 0);
         check("drop_obj_done", bus.obj_done_out, od);
         @(posedge clk_in); #1;
         check("drop_pulse_clr", {bus.tri_drop_out, bus.obj_done_out}, 0);
         check("drop_ready", bus.ready_out, 1);
      end else begin
         check("emit_valid", bus.valid_out, 1);
         check("emit_no_drop", bus.tri_drop_out, 0);
         for (int i = 0; i < 3; i++)
            check($sformatf("coor_v%0d", i),
                  {bus.coor_out[i][2], bus.coor_out[i][1], bus.coor_out[i][0]},
                  (ex[i] << 18) | (ey[i] << 9) | ez[i]);
         snap = bus.coor_out;
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk_in); #1;
            if (!bus.valid_out || bus.coor_out != snap || bus.ready_out || bus.obj_done_out)
               stable = 1'b0;
         end
         check("hold_stable", stable, 1);
         bus.ready_in = 1'b1;
         @(posedge clk_in); #1;
         bus.ready_in = 1'b0;
         check("retire_valid", bus.valid_out, 0);
         check("retire_obj_done", bus.obj_done_out, od);
         check("retire_ready", bus.ready_out, 1);
         @(posedge clk_in); #1;
         check("obj_done_clr", bus.obj_done_out, 0);
      end
   endtask

   function automatic longint rnd_xy();
      longint r;
      case ($urandom_range(0, 3))
         0:       r = 2 * ONE;
         1, 2:    r = 20 * ONE;
         default: r = 200 * ONE;
      endcase
      return longint'($urandom_range(0, 32'(2 * r))) - r;
   endfunction

   function automatic longint rnd_z();
      case ($urandom_range(0, 7))
         0:       return longint'($urandom_range(0, 32'hFFFF));
         1:       return -longint'($urandom_range(1, 100 * 65536));
         default: return longint'($urandom_range(65536, 1000 * 65536));
      endcase
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_in  = 1'b1;
      bus.valid_in = 1'b0;
      bus.obj_done_in = 1'b0;
      bus.ready_in = 1'b0;
      bus.coor_in = '0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_ready", bus.ready_out, 0);
      check("rst_valid", bus.valid_out, 0);
      check("rst_coor", longint'(bus.coor_out), 0);
      check("rst_pulses", {bus.tri_drop_out, bus.obj_done_out}, 0);
      rst_in = 1'b0;
      #1;
      check("post_rst_ready", bus.ready_out, 1);

      // front-facing triangle
      set_v(0, ONE, ONE, 10 * ONE, 0);
      set_v(1, 0, -ONE, 10 * ONE, 0);
      set_v(2, -ONE, ONE, 10 * ONE, 0);
      run_tri(0);
      // reversed winding
      set_v(1, -ONE, ONE, 10 * ONE, 0);
      set_v(2, 0, -ONE, 10 * ONE, 0);
      run_tri(0);
      // near clip at z=0.5, then z=0, with obj_done on a dropped triangle
      set_v(0, ONE, ONE, 10 * ONE, 0);
      set_v(1, 0, -ONE, 32'h0000_8000, 0);
      set_v(2, -ONE, ONE, 10 * ONE, 1);
      run_tri(0);
      set_v(1, 0, -ONE, 0, 0);
      set_v(2, -ONE, ONE, 10 * ONE, 0);
      run_tri(0);
      // saturation and clamping
      set_v(0, 100 * ONE, 0, 10 * ONE, 0);
      set_v(1, -100 * ONE, 0, 10 * ONE, 0);
      set_v(2, 0, 100 * ONE, 10 * ONE, 0);
      run_tri(0);
      // long back-pressure and obj_done on the emitted triangle
      set_v(0, ONE, ONE, 10 * ONE, 0);
      set_v(1, 0, -ONE, 10 * ONE, 0);
      set_v(2, -ONE, ONE, 10 * ONE, 1);
      run_tri(20);

      // reset in the middle of the third vertex divide
      send_vertex(0);
      wait_ready("mid_v0_ready_lat");
      send_vertex(1);
      wait_ready("mid_v1_ready_lat");
      send_vertex(2);
      repeat (5) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      #1;
      check("mid_rst_outputs",
            {bus.ready_out, bus.valid_out, bus.tri_drop_out, bus.obj_done_out}, 0);
      check("mid_rst_coor", longint'(bus.coor_out), 0);
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      check("mid_rst_no_pulse", {bus.tri_drop_out, bus.obj_done_out, bus.valid_out}, 0);
      set_v(2, -ONE, ONE, 10 * ONE, 0);
      run_tri(1);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 3; i++)
            set_v(i, rnd_xy(), rnd_xy(), rnd_z(), 1'($urandom_range(0, 3) == 0));
         run_tri(int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
